bnn_seq: RTL and testbench

Layer sequencer directly upstream of the BNN accelerator's memory-mapped command port. Consumes a stream of 32-bit binarized input words and turns them into the accelerator's command sequence for one output word: ini, acc, pool, norm. It then waits for the accelerator pipeline to drain and returns the 32 activation bits as one output word. It is the only master on the accelerator's p_* port.

---
 rtl/bnn_pkg.sv | 26 ++
 rtl/bnn_cmd_enc.sv | 48 ++++
 rtl/bnn_seq.sv | 161 ++++++++++++++++
 tb/tb_bnn_seq.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN layer sequencer: accelerator address map,
// sequencer state encoding and command kinds.
package bnn_pkg;

  localparam logic [31:0] BNN_INI_ADDR  = 32'h0000_1000;
  localparam logic [31:0] BNN_POOL_ADDR = 32'h0000_1004;
  localparam logic [3:0]  BNN_CTL_BE    = 4'hF;
  localparam logic [3:0]  BNN_ACC_BE    = 4'hF;
  localparam logic [3:0]  BNN_NORM_BE   = 4'hB;
  localparam logic [3:0]  BNN_NORM8_BE  = 4'h9;
  localparam logic [1:0]  BNN_DRAIN     = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_INI, S_ACC, S_POOL, S_NORM, S_DRAIN, S_OUT
  } bnn_state_e;

  typedef enum logic [2:0] {
    CMD_NONE, CMD_INI, CMD_ACC, CMD_POOL, CMD_NORM, CMD_NORM8
  } bnn_cmd_e;

  // Parameter rows are word addresses inside the low 4 KiB window.
  function automatic logic [31:0] bnn_row_addr(input logic [9:0] row);
    return {20'b0, row, 2'b00};
  endfunction

endpackage

// File: rtl/bnn_cmd_enc.sv
// Combinational encoder from a command kind plus row/data to the
// accelerator bus fields. CMD_NONE drives all-zero fields.
module bnn_cmd_enc
  import bnn_pkg::*;
(
  input  bnn_cmd_e    kind_i,
  input  logic [9:0]  row_i,
  input  logic [31:0] data_i,
  output logic [31:0] addr_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    addr_o  = '0;
    be_o    = '0;
    wdata_o = '0;
    case (kind_i)
      CMD_INI: begin
        addr_o  = BNN_INI_ADDR;
        be_o    = BNN_CTL_BE;
        wdata_o = data_i;
      end
      CMD_ACC: begin
        addr_o  = bnn_row_addr(row_i);
        be_o    = BNN_ACC_BE;
        wdata_o = data_i;
      end
      CMD_POOL: begin
        addr_o  = BNN_POOL_ADDR;
        be_o    = BNN_CTL_BE;
        wdata_o = data_i;
      end
      CMD_NORM: begin
        addr_o  = bnn_row_addr(row_i);
        be_o    = BNN_NORM_BE;
        wdata_o = data_i;
      end
      CMD_NORM8: begin
        addr_o  = bnn_row_addr(row_i);
        be_o    = BNN_NORM8_BE;
        wdata_o = data_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bnn_seq.sv
// BNN layer sequencer: turns a stream of binarized input words into the
// ini/acc/pool/norm command sequence for one output word and returns it.
module bnn_seq
  import bnn_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  input  logic [6:0]  cfg_n_in,
  input  logic [2:0]  cfg_n_pool,
  input  logic [9:0]  cfg_row_base,
  input  logic [9:0]  cfg_norm_row,
  input  logic        cfg_norm8,
  input  logic [15:0] cfg_bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        p_req,
  output logic        p_we,
  output logic [3:0]  p_be,
  output logic [31:0] p_addr,
  output logic [31:0] p_wdata,
  input  logic        p_gnt,
  input  logic [31:0] p_rdata
);

  bnn_state_e  state_q;
  logic [6:0]  n_in_q;
  logic [2:0]  n_pool_q;
  logic [9:0]  row_base_q;
  logic [9:0]  norm_row_q;
  logic        norm8_q;
  logic [15:0] bias_q;
  logic [6:0]  i_q;
  logic [2:0]  w_q;
  logic [1:0]  drain_q;
  logic [31:0] out_data_q;

  bnn_cmd_e    cmd_kind;
  logic [31:0] cmd_data;
  logic [9:0]  cmd_row;
  logic        cmd_fire;
  logic        last_in;
  logic        last_win;

  assign cmd_fire = p_req & p_gnt;
  assign last_in  = (i_q == n_in_q - 7'd1);
  assign last_win = (w_q == n_pool_q - 3'd1);
  // Row arithmetic is 10 bits wide so the parameter row wraps at 1024.
  assign cmd_row  = (state_q == S_NORM) ? norm_row_q : (row_base_q + {3'b0, i_q});

  always_comb begin
    cmd_kind = CMD_NONE;
    cmd_data = '0;
    p_req    = 1'b0;
    case (state_q)
      S_INI: begin
        cmd_kind = CMD_INI;
        cmd_data = {16'b0, bias_q};
        p_req    = 1'b1;
      end
      S_ACC: begin
        cmd_kind = CMD_ACC;
        cmd_data = in_data;
        p_req    = in_valid;
      end
      S_POOL: begin
        cmd_kind = CMD_POOL;
        cmd_data = last_win ? 32'b0 : {16'b0, bias_q};
        p_req    = 1'b1;
      end
      S_NORM: begin
        cmd_kind = norm8_q ? CMD_NORM8 : CMD_NORM;
        p_req    = 1'b1;
      end
      default: ;
    endcase
  end

  bnn_cmd_enc u_enc (
    .kind_i  (cmd_kind),
    .row_i   (cmd_row),
    .data_i  (cmd_data),
    .addr_o  (p_addr),
    .be_o    (p_be),
    .wdata_o (p_wdata)
  );

  assign p_we      = p_req;
  assign in_ready  = (state_q == S_ACC) & p_gnt;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_in_q     <= 7'd1;
      n_pool_q   <= 3'd1;
      row_base_q <= '0;
      norm_row_q <= '0;
      norm8_q    <= 1'b0;
      bias_q     <= '0;
      i_q        <= '0;
      w_q        <= '0;
      drain_q    <= '0;
      out_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          n_in_q     <= (cfg_n_in == 7'd0) ? 7'd1 : cfg_n_in;
          n_pool_q   <= (cfg_n_pool == 3'd0) ? 3'd1 : cfg_n_pool;
          row_base_q <= cfg_row_base;
          norm_row_q <= cfg_norm_row;
          norm8_q    <= cfg_norm8;
          bias_q     <= cfg_bias;
          i_q        <= '0;
          w_q        <= '0;
          state_q    <= S_INI;
        end
        S_INI: if (cmd_fire) state_q <= S_ACC;
        S_ACC: if (cmd_fire) begin
          if (last_in) begin
            i_q     <= '0;
            state_q <= S_POOL;
          end else begin
            i_q <= i_q + 7'd1;
          end
        end
        S_POOL: if (cmd_fire) begin
          if (last_win) begin
            state_q <= S_NORM;
          end else begin
            w_q     <= w_q + 3'd1;
            state_q <= S_ACC;
          end
        end
        S_NORM: if (cmd_fire) begin
          drain_q <= '0;
          state_q <= S_DRAIN;
        end
        // The last drain cycle is exactly three cycles after the norm was accepted.
        S_DRAIN: begin
          if (drain_q == BNN_DRAIN - 2'd1) begin
            out_data_q <= p_rdata;
            state_q    <= S_OUT;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        S_OUT: if (out_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_seq.sv
// Directed testbench for bnn_seq with a small accelerator model whose
// activation word is a running signature of accepted commands, visible 3 cycles later.
module tb_bnn_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic [6:0]  cfg_n_in = '0;
  logic [2:0]  cfg_n_pool = '0;
  logic [9:0]  cfg_row_base = '0;
  logic [9:0]  cfg_norm_row = '0;
  logic        cfg_norm8 = 1'b0;
  logic [15:0] cfg_bias = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        p_req, p_we;
  logic [3:0]  p_be;
  logic [31:0] p_addr, p_wdata;
  logic        p_gnt = 1'b1;
  logic [31:0] p_rdata;

  int checks = 0;
  int failures = 0;

  logic [31:0] src_mem [0:63];
  int          n_src, src_idx, n_hs, lat;
  logic [31:0] out_first, exp_out, basic_out;
  logic [31:0] log_addr[$], log_wdata[$], exp_addr[$], exp_wdata[$];
  logic [3:0]  log_be[$], exp_be[$];

  localparam logic [31:0] SEED = 32'h1234_5678;

  bnn_seq dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .cfg_n_in(cfg_n_in), .cfg_n_pool(cfg_n_pool), .cfg_row_base(cfg_row_base),
    .cfg_norm_row(cfg_norm_row), .cfg_norm8(cfg_norm8), .cfg_bias(cfg_bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .p_req(p_req), .p_we(p_we), .p_be(p_be), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_rdata(p_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mix(input logic [31:0] h, input logic [31:0] a,
                                      input logic [31:0] d, input logic [3:0] b);
    logic [31:0] dd;
    dd = (b == 4'hF) ? d : 32'h0;
    return {h[26:0], h[31:27]} ^ a ^ (dd * 32'h9E37_79B1) ^ {28'b0, b};
  endfunction

  // Accelerator model: ini reseeds, every other command folds into the signature.
  logic [31:0] acc_sig = '0, pipe1 = '0, pipe2 = '0;
  always @(posedge clk) begin
    if (p_req && p_gnt)
      acc_sig <= mix((p_addr == 32'h1000) ? SEED : acc_sig, p_addr, p_wdata, p_be);
    pipe1 <= acc_sig;
    pipe2 <= pipe1;
  end
  assign p_rdata = pipe2;

  function automatic void add_exp(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    exp_addr.push_back(a);
    exp_be.push_back(b);
    exp_wdata.push_back(d);
    exp_out = mix((a == 32'h1000) ? SEED : exp_out, a, d, b);
  endfunction

  function automatic void build_exp(input int ni, input int np, input int rb,
                                    input int nr, input int n8, input int bias);
    int k;
    int eni, enp;
    eni = (ni == 0) ? 1 : ni;
    enp = (np == 0) ? 1 : np;
    k = 0;
    exp_addr.delete(); exp_be.delete(); exp_wdata.delete();
    exp_out = '0;
    add_exp(32'h1000, 4'hF, 32'(bias));
    for (int w = 0; w < enp; w++) begin
      for (int i = 0; i < eni; i++) begin
        add_exp(32'(((rb + i) % 1024) * 4), 4'hF, src_mem[k]);
        k++;
      end
      add_exp(32'h1004, 4'hF, (w == enp - 1) ? 32'h0 : 32'(bias));
    end
    add_exp(32'(nr * 4), (n8 != 0) ? 4'h9 : 4'hB, 32'h0);
  endfunction

  // Index of first differing command, -2 on length difference, -1 when equal.
  function automatic int seq_diff();
    if (log_addr.size() != exp_addr.size()) return -2;
    foreach (exp_addr[k])
      if (log_addr[k] !== exp_addr[k] || log_be[k] !== exp_be[k] ||
          (exp_be[k] == 4'hF && log_wdata[k] !== exp_wdata[k])) return k;
    return -1;
  endfunction

  task automatic set_cfg(input int ni, input int np, input int rb, input int nr,
                         input int n8, input int bias, input logic [31:0] salt);
    cfg_n_in     = 7'(ni);
    cfg_n_pool   = 3'(np);
    cfg_row_base = 10'(rb);
    cfg_norm_row = 10'(nr);
    cfg_norm8    = (n8 != 0);
    cfg_bias     = 16'(bias);
    n_src = ((ni == 0) ? 1 : ni) * ((np == 0) ? 1 : np);
    for (int k = 0; k < 64; k++) src_mem[k] = salt ^ (32'(k) * 32'h0101_0011);
  endtask

  // Runs one output word; called aligned #1 after a rising edge, returns likewise.
  task automatic run_word(input int stall_at, input int stall_len, input int gap_at,
                          input int gap_len, input int hold_out);
    int cyc, hold_left;
    bit seen, done, gap, prev_stalled;
    logic [31:0] prev_addr, prev_wdata;
    log_addr.delete(); log_be.delete(); log_wdata.delete();
    n_hs = 0; src_idx = 0; lat = -1;
    cyc = 0; hold_left = hold_out; seen = 0; done = 0; prev_stalled = 0;
    prev_addr = '0; prev_wdata = '0;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1; p_gnt = 1'b1;
    while (!done) begin
      @(posedge clk); #1;
      cyc++;
      start     = seen && (hold_left == 5);
      p_gnt     = !(cyc >= stall_at && cyc < stall_at + stall_len);
      gap       = (cyc >= gap_at && cyc < gap_at + gap_len);
      in_valid  = !gap && (src_idx < n_src);
      in_data   = in_valid ? src_mem[src_idx] : 32'hDEAD_BEEF;
      out_ready = (hold_left == 0);
      @(negedge clk);
      if (!p_gnt && p_req) begin
        checks++;
        if (in_ready !== 1'b0)
          $display("FAIL stall_in_ready cyc=%0d got=%b want=0", cyc, in_ready);
        if (in_ready !== 1'b0) failures++;
        if (prev_stalled) begin
          checks++;
          if (p_addr !== prev_addr || p_wdata !== prev_wdata) begin
            $display("FAIL stall_hold cyc=%0d got=%h/%h want=%h/%h", cyc, p_addr, p_wdata, prev_addr, prev_wdata);
            failures++;
          end
        end
      end
      if (gap) begin
        checks++;
        if (p_req !== 1'b0) begin
          $display("FAIL gap_p_req cyc=%0d got=%b want=0", cyc, p_req);
          failures++;
        end
      end
      prev_stalled = p_req && !p_gnt;
      prev_addr = p_addr;
      prev_wdata = p_wdata;
      if (p_req && p_gnt) begin
        log_addr.push_back(p_addr);
        log_be.push_back(p_be);
        log_wdata.push_back(p_wdata);
      end
      if (in_valid && in_ready) begin
        n_hs++;
        src_idx++;
      end
      if (out_valid) begin
        if (!seen) begin
          seen = 1; lat = cyc; out_first = out_data;
        end else begin
          checks++;
          if (out_data !== out_first) begin
            $display("FAIL out_hold cyc=%0d got=%h want=%h", cyc, out_data, out_first);
            failures++;
          end
        end
        if (out_ready) done = 1;
        else hold_left--;
      end
      if (cyc > 400) begin
        $display("FAIL timeout cyc=%0d got=no_out want=out_valid", cyc);
        failures++;
        done = 1;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; p_gnt = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, in_ready, out_valid, p_req, p_we} !== 5'b0 || out_data !== 32'h0 ||
        p_be !== 4'h0 || p_addr !== 32'h0 || p_wdata !== 32'h0) begin
      $display("FAIL reset_values got=%b%b%b%b%b/%h/%h/%h/%h want=00000/0/0/0/0",
               busy, in_ready, out_valid, p_req, p_we, out_data, p_be, p_addr, p_wdata);
      failures++;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL reset_blocks_start got=%b want=0", busy);
      failures++;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    set_cfg(2, 1, 5, 9, 0, 3, 32'hA5A5_0F0F);
    run_word(0, 0, 0, 0, 0);
    build_exp(2, 1, 5, 9, 0, 3);
    basic_out = out_first;
    checks++;
    if (lat !== 9) begin $display("FAIL basic_latency got=%0d want=9", lat); failures++; end
    checks++;
    if (seq_diff() != -1) begin $display("FAIL basic_seq got=diff@%0d want=-1", seq_diff()); failures++; end
    if (log_addr.size() == 5) begin
      checks++;
      if (log_addr[0] !== 32'h1000 || log_wdata[0] !== 32'h3) begin
        $display("FAIL basic_ini got=%h/%h want=1000/3", log_addr[0], log_wdata[0]); failures++;
      end
      checks++;
      if (log_addr[1] !== 32'h14 || log_addr[2] !== 32'h18) begin
        $display("FAIL basic_acc_rows got=%h,%h want=14,18", log_addr[1], log_addr[2]); failures++;
      end
      checks++;
      if (log_addr[3] !== 32'h1004 || log_wdata[3] !== 32'h0) begin
        $display("FAIL basic_pool got=%h/%h want=1004/0", log_addr[3], log_wdata[3]); failures++;
      end
      checks++;
      if (log_addr[4] !== 32'h24 || log_be[4] !== 4'hB) begin
        $display("FAIL basic_norm got=%h/%h want=24/b", log_addr[4], log_be[4]); failures++;
      end
    end
    checks++;
    if (out_first !== exp_out) begin $display("FAIL basic_out got=%h want=%h", out_first, exp_out); failures++; end
    $display("test_basic lat=%0d out=%h cmds=%0d", lat, out_first, log_addr.size());
  endtask

  task automatic test_multi_pool();
    set_cfg(1, 4, 40, 12, 1, 16'h00AB, 32'h0BAD_F00D);
    run_word(0, 0, 0, 0, 0);
    build_exp(1, 4, 40, 12, 1, 16'h00AB);
    checks++;
    if (lat !== 14) begin $display("FAIL multi_latency got=%0d want=14", lat); failures++; end
    checks++;
    if (seq_diff() != -1) begin $display("FAIL multi_seq got=diff@%0d want=-1", seq_diff()); failures++; end
    checks++;
    if (n_hs !== 4) begin $display("FAIL multi_in_hs got=%0d want=4", n_hs); failures++; end
    if (log_addr.size() == 10) begin
      checks++;
      if (log_wdata[2] !== 32'hAB || log_wdata[6] !== 32'hAB || log_wdata[8] !== 32'h0) begin
        $display("FAIL multi_pool_wdata got=%h,%h,%h want=ab,ab,0", log_wdata[2], log_wdata[6], log_wdata[8]); failures++;
      end
      checks++;
      if (log_addr[7] !== 32'hA0 || log_be[9] !== 4'h9) begin
        $display("FAIL multi_acc_norm8 got=%h/%h want=a0/9", log_addr[7], log_be[9]); failures++;
      end
    end
    checks++;
    if (out_first !== exp_out) begin $display("FAIL multi_out got=%h want=%h", out_first, exp_out); failures++; end
    $display("test_multi_pool lat=%0d hs=%0d out=%h", lat, n_hs, out_first);
  endtask

  task automatic test_gnt_stall();
    set_cfg(2, 1, 5, 9, 0, 3, 32'hA5A5_0F0F);
    run_word(3, 3, 0, 0, 0);
    build_exp(2, 1, 5, 9, 0, 3);
    checks++;
    if (lat !== 12) begin $display("FAIL stall_latency got=%0d want=12", lat); failures++; end
    checks++;
    if (seq_diff() != -1 || n_hs !== 2) begin
      $display("FAIL stall_seq got=diff@%0d hs=%0d want=-1 hs=2", seq_diff(), n_hs); failures++;
    end
    checks++;
    if (out_first !== basic_out) begin $display("FAIL stall_out got=%h want=%h", out_first, basic_out); failures++; end
    $display("test_gnt_stall lat=%0d out=%h", lat, out_first);
  endtask

  task automatic test_in_gap();
    logic [31:0] ref_out;
    set_cfg(4, 1, 100, 3, 0, 16'h0777, 32'h3C3C_5A5A);
    run_word(0, 0, 0, 0, 0);
    ref_out = out_first;
    checks++;
    if (lat !== 11) begin $display("FAIL nogap_latency got=%0d want=11", lat); failures++; end
    run_word(0, 0, 3, 5, 0);
    build_exp(4, 1, 100, 3, 0, 16'h0777);
    checks++;
    if (lat !== 16) begin $display("FAIL gap_latency got=%0d want=16", lat); failures++; end
    checks++;
    if (out_first !== ref_out || out_first !== exp_out) begin
      $display("FAIL gap_out got=%h want=%h", out_first, exp_out); failures++;
    end
    $display("test_in_gap lat=%0d out=%h", lat, out_first);
  endtask

  task automatic test_row_wrap();
    set_cfg(4, 1, 1022, 1023, 1, 0, 32'h7777_1111);
    run_word(0, 0, 0, 0, 0);
    build_exp(4, 1, 1022, 1023, 1, 0);
    checks++;
    if (seq_diff() != -1) begin $display("FAIL wrap_seq got=diff@%0d want=-1", seq_diff()); failures++; end
    if (log_addr.size() == 7) begin
      checks++;
      if (log_addr[1] !== 32'hFF8 || log_addr[2] !== 32'hFFC || log_addr[3] !== 32'h0 || log_addr[4] !== 32'h4) begin
        $display("FAIL wrap_rows got=%h,%h,%h,%h want=ff8,ffc,0,4", log_addr[1], log_addr[2], log_addr[3], log_addr[4]);
        failures++;
      end
    end
    $display("test_row_wrap cmds=%0d out=%h", log_addr.size(), out_first);
  endtask

  task automatic test_reset_mid();
    set_cfg(4, 1, 5, 9, 0, 3, 32'h1357_9BDF);
    start = 1'b1; p_gnt = 1'b1; in_valid = 1'b1; in_data = src_mem[0];
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (p_req !== 1'b1 || in_ready !== 1'b1) begin
      $display("FAIL mid_in_acc got=%b%b want=11", p_req, in_ready); failures++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (p_req !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h0) begin
      $display("FAIL mid_reset got=%b%b%b/%h want=000/0", p_req, busy, in_ready, out_data); failures++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    run_word(0, 0, 0, 0, 0);
    build_exp(4, 1, 5, 9, 0, 3);
    checks++;
    if (seq_diff() != -1 || lat !== 11) begin
      $display("FAIL mid_restart got=diff@%0d lat=%0d want=-1 lat=11", seq_diff(), lat); failures++;
    end
    checks++;
    if (out_first !== exp_out) begin $display("FAIL mid_out got=%h want=%h", out_first, exp_out); failures++; end
    $display("test_reset_mid lat=%0d out=%h", lat, out_first);
  endtask

  task automatic test_out_backpressure();
    set_cfg(2, 1, 5, 9, 0, 3, 32'hA5A5_0F0F);
    run_word(0, 0, 0, 0, 10);
    checks++;
    if (lat !== 9 || out_first !== basic_out) begin
      $display("FAIL bp_first got=%0d/%h want=9/%h", lat, out_first, basic_out); failures++;
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      $display("FAIL bp_after got=%b%b want=00", busy, out_valid); failures++;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (p_req !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL bp_start_ignored k=%0d got=%b%b want=00", k, p_req, busy); failures++;
      end
      @(posedge clk); #1;
    end
    $display("test_out_backpressure lat=%0d out=%h", lat, out_first);
  endtask

  task automatic test_zero_cfg();
    set_cfg(0, 0, 77, 2, 0, 16'h0010, 32'hFACE_0001);
    run_word(0, 0, 0, 0, 0);
    build_exp(0, 0, 77, 2, 0, 16'h0010);
    checks++;
    if (lat !== 8 || seq_diff() != -1) begin
      $display("FAIL zero_cfg got=lat%0d diff@%0d want=lat8 diff@-1", lat, seq_diff()); failures++;
    end
    $display("test_zero_cfg lat=%0d cmds=%0d", lat, log_addr.size());
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_pool();
    test_gnt_stall();
    test_in_gap();
    test_row_wrap();
    test_reset_mid();
    test_out_backpressure();
    test_zero_cfg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
